// File: rtl/can_pkg.sv
// ---------------------------------------------------------------------------
// can_pkg
// Shared constants and types for the CAN receive path: FSM state encoding,
// CRC-15 polynomial, bit-stuffing limit, idle/intermission/EOF lengths and
// field widths. Also a helper that turns RTR/DLC into a data-field length.
// ---------------------------------------------------------------------------
package can_pkg;

   typedef enum logic [3:0] {
      ST_WAIT_IDLE = 4'd0,
      ST_IDLE      = 4'd1,
      ST_ARB       = 4'd2,
      ST_CTRL      = 4'd3,
      ST_DATA      = 4'd4,
      ST_CRC       = 4'd5,
      ST_CRC_DELIM = 4'd6,
      ST_ACK_SLOT  = 4'd7,
      ST_ACK_DELIM = 4'd8,
      ST_EOF       = 4'd9,
      ST_ERROR     = 4'd10
   } can_rx_state_e;

   localparam logic [14:0] CAN_CRC_POLY    = 15'h4599;
   localparam int unsigned CAN_STUFF_LIMIT = 5;
   localparam int unsigned CAN_IDLE_BITS   = 11;
   localparam int unsigned CAN_IFS_BITS    = 3;
   localparam int unsigned CAN_EOF_BITS    = 7;
   localparam int unsigned CAN_ID_W        = 11;
   localparam int unsigned CAN_DLC_W       = 4;
   localparam int unsigned CAN_CRC_W       = 15;

   // Number of data-field bits: min(DLC,8) bytes, none for a remote frame.
   function automatic logic [6:0] can_data_bits(input logic                 rtr,
                                                 input logic [CAN_DLC_W-1:0] dlc);
      logic [6:0] nbits;
      if (rtr) begin
         nbits = '0;
      end else if (dlc > 4'd8) begin
         nbits = 7'd64;
      end else begin
         nbits = {dlc, 3'b000};
      end
      return nbits;
   endfunction

endpackage

// File: rtl/can_crc15.sv
// ---------------------------------------------------------------------------
// can_crc15
// Serial CAN CRC-15 generator/checker, one bit per enable.
//   clk, rst : clock, synchronous active-high reset
//   clr      : force the register to 0 (takes priority over en)
//   en       : shift din into the CRC
//   din      : serial data bit
//   crc      : current CRC register
// ---------------------------------------------------------------------------
module can_crc15
   import can_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 en,
   input  logic                 din,
   output logic [CAN_CRC_W-1:0] crc
);

   logic [CAN_CRC_W-1:0] crc_q, crc_d;
   logic                 fb;

   always_comb begin
      fb    = din ^ crc_q[CAN_CRC_W-1];
      crc_d = crc_q;
      if (clr) begin
         crc_d = '0;
      end else if (en) begin
         crc_d = {crc_q[CAN_CRC_W-2:0], 1'b0} ^ (fb ? CAN_CRC_POLY : '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         crc_q <= '0;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc = crc_q;

endmodule

// File: rtl/can_rx_container.sv
// ---------------------------------------------------------------------------
// can_rx_container
// CAN 2.0A receiver: synchronizes rx, samples on sample_tick, destuffs,
// parses standard data/remote frames, checks CRC-15 and fixed-form fields,
// drives the ACK slot for good frames and publishes the last good frame.
//   clk, rst        : 20 MHz clock, synchronous active-high reset
//   rx              : asynchronous bus level (0 = dominant)
//   sample_tick     : one-cycle pulse at each bit's sample point
//   ack_drive       : request to drive dominant in the ACK slot
//   rxing           : frame in progress (SOF through last EOF bit)
//   frame_valid     : one-cycle pulse, rx_* hold a new frame
//   rx_address/dlc/rtr/data : last good frame (data byte 0 in [63:56])
//   stuff_err, crc_err, form_err : one-cycle error pulses
// ---------------------------------------------------------------------------
module can_rx_container
   import can_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   input  logic                 sample_tick,
   output logic                 ack_drive,
   output logic                 rxing,
   output logic                 frame_valid,
   output logic [CAN_ID_W-1:0]  rx_address,
   output logic [CAN_DLC_W-1:0] rx_dlc,
   output logic                 rx_rtr,
   output logic [63:0]          rx_data,
   output logic                 stuff_err,
   output logic                 crc_err,
   output logic                 form_err
);

   localparam logic [2:0] STUFF_LIM = 3'(CAN_STUFF_LIMIT);
   localparam logic [6:0] IDLE_LONG = 7'(CAN_IDLE_BITS);
   localparam logic [6:0] IDLE_IFS  = 7'(CAN_IFS_BITS);
   localparam logic [6:0] EOF_LAST  = 7'(CAN_EOF_BITS - 1);
   localparam logic [6:0] ARB_LAST  = 7'(CAN_ID_W);      // 11 ID bits + RTR
   localparam logic [6:0] CTRL_LAST = 7'd5;              // IDE, r0, DLC[3:0]
   localparam logic [6:0] CRC_LAST  = 7'(CAN_CRC_W - 1);

   can_rx_state_e        state_q, state_d;
   logic                 rx_meta_q, rx_sync_q;
   logic [6:0]           cnt_q, cnt_d;
   logic                 long_idle_q, long_idle_d;
   logic [2:0]           run_q, run_d;
   logic                 last_q, last_d;
   logic [CAN_ID_W:0]    arb_q, arb_d;
   logic [CAN_DLC_W-1:0] dlc_q, dlc_d;
   logic [63:0]          data_q, data_d;
   logic [CAN_CRC_W-1:0] crc_rx_q, crc_rx_d;
   logic [6:0]           nbits_q, nbits_d;
   logic                 ack_q, ack_d;
   logic                 rxing_q, rxing_d;
   logic                 fv_q, fv_d;
   logic                 serr_q, serr_d;
   logic                 cerr_q, cerr_d;
   logic                 ferr_q, ferr_d;
   logic [CAN_ID_W-1:0]  out_addr_q, out_addr_d;
   logic [CAN_DLC_W-1:0] out_dlc_q, out_dlc_d;
   logic                 out_rtr_q, out_rtr_d;
   logic [63:0]          out_data_q, out_data_d;

   logic                 bit_v;
   logic                 in_stuff_region;
   logic                 stuff_pos;
   logic [CAN_DLC_W-1:0] dlc_shift;
   logic [6:0]           nb_c;
   logic [6:0]           idle_target;
   logic [5:0]           data_idx;
   logic                 crc_clr, crc_en;
   logic [CAN_CRC_W-1:0] crc_calc;

   can_crc15 u_crc (
      .clk (clk),
      .rst (rst),
      .clr (crc_clr),
      .en  (crc_en),
      .din (rx_sync_q),
      .crc (crc_calc)
   );

   always_comb begin
      bit_v       = rx_sync_q;
      dlc_shift   = {dlc_q[CAN_DLC_W-2:0], bit_v};
      nb_c        = can_data_bits(arb_q[0], dlc_shift);
      idle_target = long_idle_q ? IDLE_LONG : IDLE_IFS;
      data_idx    = 6'd63 - cnt_q[5:0];

      // The stuff bit that may follow the last CRC bit is checked while the
      // FSM already sits in CRC_DELIM; the delimiter is the tick after it.
      in_stuff_region = (state_q == ST_ARB) || (state_q == ST_CTRL) ||
                        (state_q == ST_DATA) || (state_q == ST_CRC) ||
                        ((state_q == ST_CRC_DELIM) && (run_q == STUFF_LIM));
      stuff_pos = in_stuff_region && (run_q == STUFF_LIM);

      state_d     = state_q;
      cnt_d       = cnt_q;
      long_idle_d = long_idle_q;
      run_d       = run_q;
      last_d      = last_q;
      arb_d       = arb_q;
      dlc_d       = dlc_q;
      data_d      = data_q;
      crc_rx_d    = crc_rx_q;
      nbits_d     = nbits_q;
      ack_d       = ack_q;
      rxing_d     = rxing_q;
      fv_d        = 1'b0;
      serr_d      = 1'b0;
      cerr_d      = 1'b0;
      ferr_d      = 1'b0;
      out_addr_d  = out_addr_q;
      out_dlc_d   = out_dlc_q;
      out_rtr_d   = out_rtr_q;
      out_data_d  = out_data_q;
      crc_clr     = 1'b0;
      crc_en      = 1'b0;

      if (sample_tick) begin
         if (stuff_pos) begin
            if (bit_v == last_q) begin
               serr_d = 1'b1;
            end else begin
               last_d = bit_v;
               run_d  = 3'd1;
            end
         end else begin
            if (in_stuff_region) begin
               run_d  = (bit_v == last_q) ? run_q + 3'd1 : 3'd1;
               last_d = bit_v;
            end
            case (state_q)
               ST_WAIT_IDLE: begin
                  if (!bit_v) begin
                     cnt_d = '0;
                  end else if (cnt_q + 7'd1 == idle_target) begin
                     cnt_d   = '0;
                     state_d = ST_IDLE;
                  end else begin
                     cnt_d = cnt_q + 7'd1;
                  end
               end
               ST_IDLE: begin
                  if (!bit_v) begin
                     // SOF is dominant, so clearing the CRC already accounts
                     // for it: a 0 shifted into a zero register leaves 0.
                     state_d  = ST_ARB;
                     cnt_d    = '0;
                     crc_clr  = 1'b1;
                     run_d    = 3'd1;
                     last_d   = 1'b0;
                     arb_d    = '0;
                     dlc_d    = '0;
                     data_d   = '0;
                     crc_rx_d = '0;
                     rxing_d  = 1'b1;
                  end
               end
               ST_ARB: begin
                  crc_en = 1'b1;
                  arb_d  = {arb_q[CAN_ID_W-1:0], bit_v};
                  if (cnt_q == ARB_LAST) begin
                     cnt_d   = '0;
                     state_d = ST_CTRL;
                  end else begin
                     cnt_d = cnt_q + 7'd1;
                  end
               end
               ST_CTRL: begin
                  crc_en = 1'b1;
                  if ((cnt_q == 7'd0) && bit_v) begin
                     ferr_d = 1'b1;
                  end else if (cnt_q == CTRL_LAST) begin
                     dlc_d   = dlc_shift;
                     nbits_d = nb_c;
                     cnt_d   = '0;
                     state_d = (nb_c == 7'd0) ? ST_CRC : ST_DATA;
                  end else begin
                     if (cnt_q >= 7'd2) begin
                        dlc_d = dlc_shift;
                     end
                     cnt_d = cnt_q + 7'd1;
                  end
               end
               ST_DATA: begin
                  crc_en           = 1'b1;
                  data_d[data_idx] = bit_v;
                  if (cnt_q + 7'd1 == nbits_q) begin
                     cnt_d   = '0;
                     state_d = ST_CRC;
                  end else begin
                     cnt_d = cnt_q + 7'd1;
                  end
               end
               ST_CRC: begin
                  crc_rx_d = {crc_rx_q[CAN_CRC_W-2:0], bit_v};
                  if (cnt_q == CRC_LAST) begin
                     cnt_d   = '0;
                     state_d = ST_CRC_DELIM;
                  end else begin
                     cnt_d = cnt_q + 7'd1;
                  end
               end
               ST_CRC_DELIM: begin
                  if (!bit_v) begin
                     ferr_d = 1'b1;
                  end else if (crc_calc != crc_rx_q) begin
                     cerr_d = 1'b1;
                  end else begin
                     ack_d   = 1'b1;
                     state_d = ST_ACK_SLOT;
                  end
               end
               ST_ACK_SLOT: begin
                  ack_d   = 1'b0;
                  state_d = ST_ACK_DELIM;
               end
               ST_ACK_DELIM: begin
                  if (!bit_v) begin
                     ferr_d = 1'b1;
                  end else begin
                     cnt_d   = '0;
                     state_d = ST_EOF;
                  end
               end
               ST_EOF: begin
                  if (!bit_v) begin
                     ferr_d = 1'b1;
                  end else if (cnt_q == EOF_LAST) begin
                     out_addr_d  = arb_q[CAN_ID_W:1];
                     out_rtr_d   = arb_q[0];
                     out_dlc_d   = dlc_q;
                     out_data_d  = data_q;
                     fv_d        = 1'b1;
                     rxing_d     = 1'b0;
                     cnt_d       = '0;
                     long_idle_d = 1'b0;
                     state_d     = ST_WAIT_IDLE;
                  end else begin
                     cnt_d = cnt_q + 7'd1;
                  end
               end
               default: ;
            endcase
         end

         if (serr_d || ferr_d || cerr_d) begin
            state_d = ST_ERROR;
            rxing_d = 1'b0;
            ack_d   = 1'b0;
         end
      end

      if (state_q == ST_ERROR) begin
         state_d     = ST_WAIT_IDLE;
         cnt_d       = '0;
         long_idle_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q   <= 1'b1;
         rx_sync_q   <= 1'b1;
         state_q     <= ST_WAIT_IDLE;
         cnt_q       <= '0;
         long_idle_q <= 1'b1;
         run_q       <= '0;
         last_q      <= 1'b0;
         arb_q       <= '0;
         dlc_q       <= '0;
         data_q      <= '0;
         crc_rx_q    <= '0;
         nbits_q     <= '0;
         ack_q       <= 1'b0;
         rxing_q     <= 1'b0;
         fv_q        <= 1'b0;
         serr_q      <= 1'b0;
         cerr_q      <= 1'b0;
         ferr_q      <= 1'b0;
         out_addr_q  <= '0;
         out_dlc_q   <= '0;
         out_rtr_q   <= 1'b0;
         out_data_q  <= '0;
      end else begin
         rx_meta_q   <= rx;
         rx_sync_q   <= rx_meta_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         long_idle_q <= long_idle_d;
         run_q       <= run_d;
         last_q      <= last_d;
         arb_q       <= arb_d;
         dlc_q       <= dlc_d;
         data_q      <= data_d;
         crc_rx_q    <= crc_rx_d;
         nbits_q     <= nbits_d;
         ack_q       <= ack_d;
         rxing_q     <= rxing_d;
         fv_q        <= fv_d;
         serr_q      <= serr_d;
         cerr_q      <= cerr_d;
         ferr_q      <= ferr_d;
         out_addr_q  <= out_addr_d;
         out_dlc_q   <= out_dlc_d;
         out_rtr_q   <= out_rtr_d;
         out_data_q  <= out_data_d;
      end
   end

   assign ack_drive   = ack_q;
   assign rxing       = rxing_q;
   assign frame_valid = fv_q;
   assign rx_address  = out_addr_q;
   assign rx_dlc      = out_dlc_q;
   assign rx_rtr      = out_rtr_q;
   assign rx_data     = out_data_q;
   assign stuff_err   = serr_q;
   assign crc_err     = cerr_q;
   assign form_err    = ferr_q;

endmodule

// File: tb/tb_can_rx_container.sv
// ---------------------------------------------------------------------------
// tb_can_rx_container
// Self-checking bench: frames are built bit by bit from the CAN field rules
// (CRC by polynomial long division, stuffing by run counting), driven onto
// rx with a 5-clock bit period, and outcomes compared to expectations.
// ---------------------------------------------------------------------------
module tb_can_rx_container;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx = 1'b1;
   logic        sample_tick = 1'b0;
   logic        ack_drive, rxing, frame_valid, rx_rtr;
   logic        stuff_err, crc_err, form_err;
   logic [10:0] rx_address;
   logic [3:0]  rx_dlc;
   logic [63:0] rx_data;

   can_rx_container dut (
      .clk         (clk),
      .rst         (rst),
      .rx          (rx),
      .sample_tick (sample_tick),
      .ack_drive   (ack_drive),
      .rxing       (rxing),
      .frame_valid (frame_valid),
      .rx_address  (rx_address),
      .rx_dlc      (rx_dlc),
      .rx_rtr      (rx_rtr),
      .rx_data     (rx_data),
      .stuff_err   (stuff_err),
      .crc_err     (crc_err),
      .form_err    (form_err)
   );

   always #25 clk = ~clk;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   // Event counters, sampled on the falling edge.
   int fv_cnt = 0, se_cnt = 0, ce_cnt = 0, fe_cnt = 0, ack_cnt = 0;
   always @(negedge clk) begin
      if (frame_valid) fv_cnt++;
      if (stuff_err)   se_cnt++;
      if (crc_err)     ce_cnt++;
      if (form_err)    fe_cnt++;
      if (ack_drive)   ack_cnt++;
   end

   typedef struct {
      logic [10:0] id;
      logic        rtr;
      logic [3:0]  dlc;
      logic [63:0] data;
      logic        ide;
      logic        flip;
      logic        eof4;
      int          exp_fv;
      int          exp_se;
      int          exp_ce;
      int          exp_fe;
      int          exp_ack;
   } vec_t;

   vec_t vecs[8];

   // Reference model of the published frame.
   logic [10:0] m_id   = '0;
   logic [3:0]  m_dlc  = '0;
   logic        m_rtr  = 1'b0;
   logic [63:0] m_data = '0;

   logic msg_q[$];
   logic bus_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Remainder of msg(x) * x^15 divided by the generator polynomial.
   function automatic logic [14:0] ref_crc();
      logic        w[$];
      logic [15:0] g;
      logic [14:0] r;
      g = {1'b1, 15'h4599};
      w = msg_q;
      repeat (15) w.push_back(1'b0);
      for (int i = 0; i + 15 < w.size(); i++) begin
         if (w[i]) begin
            for (int j = 0; j < 16; j++) w[i+j] = w[i+j] ^ g[15-j];
         end
      end
      for (int j = 0; j < 15; j++) r[14-j] = w[w.size()-15+j];
      return r;
   endfunction

   function automatic int nbytes_of(input logic rtr, input logic [3:0] dlc);
      if (rtr) return 0;
      return (dlc > 8) ? 8 : int'(dlc);
   endfunction

   task automatic build_frame(input vec_t v);
      logic [14:0] crc;
      int          nb, run;
      logic        prev;
      msg_q = {};
      msg_q.push_back(1'b0);
      for (int i = 10; i >= 0; i--) msg_q.push_back(v.id[i]);
      msg_q.push_back(v.rtr);
      msg_q.push_back(v.ide);
      msg_q.push_back(1'b0);
      for (int i = 3; i >= 0; i--) msg_q.push_back(v.dlc[i]);
      nb = nbytes_of(v.rtr, v.dlc);
      for (int i = 0; i < nb * 8; i++) msg_q.push_back(v.data[63-i]);
      crc = ref_crc();
      if (v.flip) crc[7] = ~crc[7];
      for (int i = 14; i >= 0; i--) msg_q.push_back(crc[i]);
      bus_q = {};
      run   = 0;
      prev  = 1'b1;
      foreach (msg_q[i]) begin
         bus_q.push_back(msg_q[i]);
         if (run > 0 && msg_q[i] == prev) run++;
         else run = 1;
         prev = msg_q[i];
         if (run == 5) begin
            bus_q.push_back(~prev);
            prev = ~prev;
            run  = 1;
         end
      end
      bus_q.push_back(1'b1);                     // CRC delimiter
      bus_q.push_back(1'b1);                     // ACK slot
      bus_q.push_back(1'b1);                     // ACK delimiter
      for (int i = 0; i < 7; i++) bus_q.push_back((v.eof4 && i == 3) ? 1'b0 : 1'b1);
   endtask

   task automatic send_bit(input logic b);
      rx = b;
      repeat (3) @(negedge clk);
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_idle(input int n);
      repeat (n) send_bit(1'b1);
   endtask

   task automatic send_bits(input int n);
      for (int i = 0; i < n && i < bus_q.size(); i++) send_bit(bus_q[i]);
   endtask

   task automatic check_fields(input string tag);
      chk({tag, ".addr"}, 64'(rx_address), 64'(m_id));
      chk({tag, ".dlc"},  64'(rx_dlc),     64'(m_dlc));
      chk({tag, ".rtr"},  64'(rx_rtr),     64'(m_rtr));
      chk({tag, ".data"}, rx_data,         m_data);
   endtask

   task automatic run_frame(input vec_t v, input string tag);
      int fv0, se0, ce0, fe0, ack0, nb;
      send_idle(12);
      fv0 = fv_cnt; se0 = se_cnt; ce0 = ce_cnt; fe0 = fe_cnt; ack0 = ack_cnt;
      build_frame(v);
      send_bits(bus_q.size());
      chk({tag, ".frame_valid"}, 64'(fv_cnt - fv0),  64'(v.exp_fv));
      chk({tag, ".stuff_err"},   64'(se_cnt - se0),  64'(v.exp_se));
      chk({tag, ".crc_err"},     64'(ce_cnt - ce0),  64'(v.exp_ce));
      chk({tag, ".form_err"},    64'(fe_cnt - fe0),  64'(v.exp_fe));
      chk({tag, ".ack_cycles"},  64'(ack_cnt - ack0), 64'(v.exp_ack));
      chk({tag, ".rxing_after"}, 64'(rxing), 64'd0);
      if (v.exp_fv != 0) begin
         nb     = nbytes_of(v.rtr, v.dlc);
         m_id   = v.id;
         m_dlc  = v.dlc;
         m_rtr  = v.rtr;
         m_data = '0;
         for (int i = 0; i < nb * 8; i++) m_data[63-i] = v.data[63-i];
      end
      check_fields(tag);
   endtask

   function automatic vec_t good_vec(input logic [10:0] id, input logic [3:0] dlc,
                                     input logic [63:0] data);
      vec_t v;
      v = '{id:id, rtr:1'b0, dlc:dlc, data:data, ide:1'b0, flip:1'b0, eof4:1'b0,
            exp_fv:1, exp_se:0, exp_ce:0, exp_fe:0, exp_ack:5};
      return v;
   endfunction

   initial begin
      #5ms;
      $display("FAIL watchdog: elapsed %0t, required below 5ms", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int   fv0, se0;

      vecs[0] = '{id:11'h123, rtr:0, dlc:4'd2,  data:64'hABCD_0000_0000_0000, ide:0, flip:0, eof4:0,
                  exp_fv:1, exp_se:0, exp_ce:0, exp_fe:0, exp_ack:5};
      vecs[1] = '{id:11'h000, rtr:0, dlc:4'd0,  data:64'h0, ide:0, flip:0, eof4:0,
                  exp_fv:1, exp_se:0, exp_ce:0, exp_fe:0, exp_ack:5};
      vecs[2] = '{id:11'h0F0, rtr:0, dlc:4'd1,  data:64'h5500_0000_0000_0000, ide:0, flip:1, eof4:0,
                  exp_fv:0, exp_se:0, exp_ce:1, exp_fe:0, exp_ack:0};
      vecs[3] = '{id:11'h2AA, rtr:0, dlc:4'd1,  data:64'h0F00_0000_0000_0000, ide:0, flip:0, eof4:1,
                  exp_fv:0, exp_se:0, exp_ce:0, exp_fe:1, exp_ack:5};
      vecs[4] = '{id:11'h155, rtr:0, dlc:4'd1,  data:64'hA500_0000_0000_0000, ide:1, flip:0, eof4:0,
                  exp_fv:0, exp_se:0, exp_ce:0, exp_fe:1, exp_ack:0};
      vecs[5] = '{id:11'h7FF, rtr:1, dlc:4'd3,  data:64'hDEAD_BEEF_0000_0000, ide:0, flip:0, eof4:0,
                  exp_fv:1, exp_se:0, exp_ce:0, exp_fe:0, exp_ack:5};
      vecs[6] = '{id:11'h0A5, rtr:0, dlc:4'd15, data:64'h0123_4567_89AB_CDEF, ide:0, flip:0, eof4:0,
                  exp_fv:1, exp_se:0, exp_ce:0, exp_fe:0, exp_ack:5};
      vecs[7] = '{id:11'h7F0, rtr:0, dlc:4'd8,  data:64'hFFFF_FFFF_0000_0000, ide:0, flip:0, eof4:0,
                  exp_fv:1, exp_se:0, exp_ce:0, exp_fe:0, exp_ack:5};

      // Reset state
      repeat (4) @(negedge clk);
      chk("reset.ack_drive",   64'(ack_drive),   64'd0);
      chk("reset.rxing",       64'(rxing),       64'd0);
      chk("reset.frame_valid", 64'(frame_valid), 64'd0);
      chk("reset.stuff_err",   64'(stuff_err),   64'd0);
      chk("reset.crc_err",     64'(crc_err),     64'd0);
      chk("reset.form_err",    64'(form_err),    64'd0);
      check_fields("reset");
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

      // Six dominant bits: stuff violation, then a frame after only 5
      // recessive bits must be ignored.
      send_idle(12);
      fv0 = fv_cnt; se0 = se_cnt;
      repeat (6) send_bit(1'b0);
      chk("stuff6.stuff_err", 64'(se_cnt - se0), 64'd1);
      chk("stuff6.rxing",     64'(rxing),        64'd0);
      send_idle(5);
      v = good_vec(11'h321, 4'd1, 64'h7700_0000_0000_0000);
      build_frame(v);
      send_bits(bus_q.size());
      chk("stuff6.ignored_fv", 64'(fv_cnt - fv0), 64'd0);
      check_fields("stuff6");
      run_frame(v, "stuff6.recover");

      // Reset in the middle of the data field.
      send_idle(12);
      v = good_vec(11'h456, 4'd8, 64'h1122_3344_5566_7788);
      build_frame(v);
      send_bits(30);
      chk("midrst.rxing_before", 64'(rxing), 64'd1);
      rst = 1'b1;
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
      repeat (3) @(negedge clk);
      m_id = '0; m_dlc = '0; m_rtr = 1'b0; m_data = '0;
      chk("midrst.rxing",       64'(rxing),       64'd0);
      chk("midrst.ack_drive",   64'(ack_drive),   64'd0);
      chk("midrst.frame_valid", 64'(frame_valid), 64'd0);
      check_fields("midrst");
      rst = 1'b0;
      rx  = 1'b1;
      @(negedge clk);
      fv0 = fv_cnt;
      send_idle(5);
      send_bits(bus_q.size());
      chk("midrst.ignored_fv", 64'(fv_cnt - fv0), 64'd0);
      check_fields("midrst.ignored");
      run_frame(v, "midrst.recover");

      // Randomized frames against the model.
      for (int i = 0; i < 20; i++) begin
         v.id   = 11'($urandom);
         v.rtr  = ($urandom_range(0, 3) == 0);
         v.dlc  = 4'($urandom_range(0, 15));
         v.data = {$urandom, $urandom};
         v.ide  = 1'b0;
         v.flip = ($urandom_range(0, 4) == 0);
         v.eof4 = 1'b0;
         v.exp_fv  = v.flip ? 0 : 1;
         v.exp_se  = 0;
         v.exp_ce  = v.flip ? 1 : 0;
         v.exp_fe  = 0;
         v.exp_ack = v.flip ? 0 : 5;
         run_frame(v, $sformatf("rand%0d", i));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
